fetch_sequencer: RTL

//  Owns the program counter and sequences fetches from the combinational

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, sequences fetches from the
// combinational instruction memory, hands each word to decode over a
// valid/ready handshake, applies branch redirects and halts at the end of
// the image or on a bad branch target.
module fetch_sequencer #(
  parameter int unsigned IMEM_BYTES  = 64,
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        branchTaken,
  input  logic [63:0] branchTarget,
  output logic [63:0] programCounter,
  input  logic [31:0] memInstruction,
  output logic        instrValid,
  input  logic        decodeReady,
  output logic [31:0] instrOut,
  output logic [63:0] instrPC,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetchCount
);

  // Highest address that still holds a whole instruction.
  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;

  // Wide enough to hold MEM_LATENCY-1 for any legal latency (>= 1).
  localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_VALID,
    ST_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;
  logic [15:0] count_q, count_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic accept;
  logic redirect;
  logic target_bad;
  logic at_end;

  // Handshake, redirect qualification and end-of-image decision.
  always_comb begin
    accept     = (state_q == ST_VALID) && decodeReady;
    redirect   = branchTaken &&
                 ((state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_VALID));
    target_bad = (branchTarget[1:0] != 2'b00) || (branchTarget > LAST_PC);
    // PC is always a multiple of 4 no greater than LAST_PC, so "PC+4 beyond
    // the last slot" reduces to "PC is the last slot" without any addition.
    at_end     = (pc_q >= LAST_PC);
  end

  // Next-state and datapath updates; a redirect overrides the normal flow.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    count_d    = count_q;
    lat_d      = lat_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = RESET_PC;
          count_d = 16'd0;
          fault_d = 1'b0;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
        lat_d   = LAT_RELOAD;
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          state_d    = ST_VALID;
          instr_d    = memInstruction;
          instr_pc_d = pc_q;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_VALID: begin
        if (accept) begin
          count_d = count_q + 16'd1;
          if (at_end) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
            pc_d    = pc_q + 64'd4;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The in-flight word is dropped, so captured outputs keep their old value.
    if (redirect) begin
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      if (target_bad) begin
        state_d = ST_HALT;
        fault_d = 1'b1;
        pc_d    = pc_q;
      end else begin
        state_d = ST_FETCH;
        pc_d    = branchTarget;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 64'd0;
      fault_q    <= 1'b0;
      count_q    <= 16'd0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      lat_q      <= lat_d;
    end
  end

  // Outputs are direct views of the registered state.
  always_comb begin
    programCounter = pc_q;
    instrValid     = (state_q == ST_VALID);
    instrOut       = instr_q;
    instrPC        = instr_pc_q;
    halted         = (state_q == ST_HALT);
    fault          = fault_q;
    fetchCount     = count_q;
  end

endmodule
